// File: rtl/bsg_manycore_net_port_arbiter.sv
// Network port arbiter: picks one valid input per cycle into a single output register.
// Round-robin over the active inputs of the topology; fixed priority for crossbar.
`ifndef BSG_SAFE_CLOG2
`define BSG_SAFE_CLOG2(x) (((x) > 1) ? $clog2(x) : 1)
`endif

package bsg_manycore_net_pkg;
    typedef enum logic [2:0] {
        e_network_mesh,
        e_network_torus,
        e_network_half_ruche_x,
        e_network_full_ruche,
        e_network_crossbar,
        e_network_max_val
    } bsg_manycore_network_cfg_e;
endpackage

module bsg_manycore_net_port_arbiter
    import bsg_manycore_net_pkg::*;
#(
    parameter bsg_manycore_network_cfg_e network_cfg_p = e_network_mesh,
    parameter int width_p  = 32,
    parameter int num_in_p = 9
) (
    input  logic                                  clk_i,
    input  logic                                  reset_n_i,
    input  logic [num_in_p-1:0]                   v_i,
    input  logic [num_in_p*width_p-1:0]           data_i,
    output logic [num_in_p-1:0]                   yumi_o,
    output logic                                  v_o,
    output logic [width_p-1:0]                    data_o,
    input  logic                                  ready_i,
    output logic [`BSG_SAFE_CLOG2(num_in_p)-1:0]  grant_id_o
);
    localparam int lg_num_in_lp = `BSG_SAFE_CLOG2(num_in_p);
    localparam int active_lp =
        (network_cfg_p == e_network_half_ruche_x) ? 7 :
        (network_cfg_p == e_network_full_ruche)   ? 9 :
        (network_cfg_p == e_network_crossbar)     ? num_in_p : 5;
    localparam bit rr_lp = (network_cfg_p != e_network_crossbar);

    if (network_cfg_p == e_network_max_val) begin : g_bad_cfg
        $error("bsg_manycore_net_port_arbiter: e_network_max_val is not a valid network_cfg_p");
    end
    if (num_in_p < active_lp) begin : g_bad_num_in
        $error("bsg_manycore_net_port_arbiter: num_in_p smaller than active input count");
    end

    logic                    v_q, v_d;
    logic [width_p-1:0]      data_q;
    logic [lg_num_in_lp-1:0] gid_q, gid_d;
    logic [lg_num_in_lp-1:0] ptr_q, ptr_d;

    logic [num_in_p-1:0]     v_act;
    logic [lg_num_in_lp-1:0] win;
    logic                    found;
    logic                    open;
    logic                    grant;
    int                      idx;

    always_comb begin
        v_act = '0;
        for (int i = 0; i < num_in_p; i++) begin
            v_act[i] = (i < active_lp) ? v_i[i] : 1'b0;
        end
    end

    // Scan active inputs starting at ptr (or at 0 for crossbar), wrapping at the active count.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int k = 0; k < active_lp; k++) begin
            idx = rr_lp ? (int'(ptr_q) + k) : k;
            if (idx >= active_lp) idx = idx - active_lp;
            if (!found && v_act[idx]) begin
                found = 1'b1;
                win   = idx[lg_num_in_lp-1:0];
            end
        end
    end

    assign open  = !v_q || ready_i;
    assign grant = reset_n_i && open && found;

    always_comb begin
        yumi_o = '0;
        if (grant) yumi_o[win] = 1'b1;
    end

    always_comb begin
        v_d   = v_q;
        gid_d = gid_q;
        ptr_d = ptr_q;
        if (grant) begin
            v_d   = 1'b1;
            gid_d = win;
            if (rr_lp) ptr_d = (int'(win) == active_lp - 1) ? '0 : win + 1'b1;
        end else if (ready_i) begin
            v_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            v_q   <= 1'b0;
            gid_q <= '0;
            ptr_q <= '0;
        end else begin
            v_q   <= v_d;
            gid_q <= gid_d;
            ptr_q <= ptr_d;
        end
    end

    // Payload is meaningless while v_o=0, so it carries no reset.
    always_ff @(posedge clk_i) begin
        if (grant) data_q <= data_i[int'(win)*width_p +: width_p];
    end

    assign v_o        = v_q;
    assign data_o     = data_q;
    assign grant_id_o = gid_q;

    a_yumi_onehot: assert property (@(posedge clk_i) disable iff (!reset_n_i) $onehot0(yumi_o))
        else $error("yumi_o has more than one bit set: %b", yumi_o);

endmodule

// File: tb/tb_bsg_manycore_net_port_arbiter.sv
// Directed bench: mesh, crossbar and full-ruche arbiters side by side on one clock/reset.
module tb_bsg_manycore_net_port_arbiter;
    import bsg_manycore_net_pkg::*;

    localparam int W = 32;
    localparam int N = 9;

    logic clk_i = 1'b0;
    logic reset_n_i;
    logic [N*W-1:0] data_i;

    logic [N-1:0] v_m, v_x, v_r;
    logic         rdy_m, rdy_x, rdy_r;
    logic [N-1:0] yumi_m, yumi_x, yumi_r;
    logic         vo_m, vo_x, vo_r;
    logic [W-1:0] do_m, do_x, do_r;
    logic [3:0]   gid_m, gid_x, gid_r;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    bsg_manycore_net_port_arbiter #(.network_cfg_p(e_network_mesh), .width_p(W), .num_in_p(N)) u_mesh (
        .clk_i(clk_i), .reset_n_i(reset_n_i), .v_i(v_m), .data_i(data_i), .yumi_o(yumi_m),
        .v_o(vo_m), .data_o(do_m), .ready_i(rdy_m), .grant_id_o(gid_m));
    bsg_manycore_net_port_arbiter #(.network_cfg_p(e_network_crossbar), .width_p(W), .num_in_p(N)) u_xbar (
        .clk_i(clk_i), .reset_n_i(reset_n_i), .v_i(v_x), .data_i(data_i), .yumi_o(yumi_x),
        .v_o(vo_x), .data_o(do_x), .ready_i(rdy_x), .grant_id_o(gid_x));
    bsg_manycore_net_port_arbiter #(.network_cfg_p(e_network_full_ruche), .width_p(W), .num_in_p(N)) u_ruche (
        .clk_i(clk_i), .reset_n_i(reset_n_i), .v_i(v_r), .data_i(data_i), .yumi_o(yumi_r),
        .v_o(vo_r), .data_o(do_r), .ready_i(rdy_r), .grant_id_o(gid_r));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [W-1:0] pkt(input int i);
        return 32'hD000_0000 + W'(i);
    endfunction

    initial begin
        for (int i = 0; i < N; i++) data_i[i*W +: W] = pkt(i);
        reset_n_i = 1'b0;
        v_m = '1; v_x = '1; v_r = '1;
        rdy_m = 1'b1; rdy_x = 1'b1; rdy_r = 1'b1;
        #1;
        chk("rst_yumi_m", yumi_m, 0);
        chk("rst_yumi_x", yumi_x, 0);
        chk("rst_yumi_r", yumi_r, 0);
        chk("rst_v_m", vo_m, 0);
        chk("rst_v_x", vo_x, 0);
        chk("rst_gid_m", gid_m, 0);

        // Mesh round-robin over all five active inputs
        #10; v_m = 9'h01F; v_x = '0; v_r = '0;
        #1;  reset_n_i = 1'b1;
        #1;  chk("mesh_first_yumi", yumi_m, 9'h001);
        for (int c = 0; c < 6; c++) begin
            tick();
            chk("mesh_rr_v", vo_m, 1);
            chk("mesh_rr_gid", gid_m, c % 5);
            chk("mesh_rr_data", do_m, pkt(c % 5));
            chk("mesh_rr_yumi", yumi_m, 9'(1 << ((c + 1) % 5)));
        end
        v_m = '0;
        #1; chk("mesh_idle_yumi", yumi_m, 0);
        tick();
        chk("mesh_drain_v", vo_m, 0);

        // Inactive mesh inputs ignored (ptr is 1 here)
        v_m = 9'h1E0;
        #1; chk("mesh_inactive_yumi", yumi_m, 0);
        tick(); chk("mesh_inactive_v", vo_m, 0);
        tick(); chk("mesh_inactive_v2", vo_m, 0);

        // Backpressure: load input 3 (ptr -> 4), then stall with inputs 1,2 waiting
        v_m = 9'h008;
        #1; chk("mesh_bp_load_yumi", yumi_m, 9'h008);
        tick();
        chk("mesh_bp_gid", gid_m, 3);
        rdy_m = 1'b0; v_m = 9'h006;
        #1; chk("mesh_bp_yumi0", yumi_m, 0);
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("mesh_bp_v", vo_m, 1);
            chk("mesh_bp_data", do_m, pkt(3));
            chk("mesh_bp_gid_hold", gid_m, 3);
            chk("mesh_bp_yumi", yumi_m, 0);
        end
        rdy_m = 1'b1;
        #1; chk("mesh_bp_release_yumi", yumi_m, 9'h002);
        tick();
        chk("mesh_bp_next_gid", gid_m, 1);
        chk("mesh_bp_next_data", do_m, pkt(1));
        chk("mesh_bp_next_yumi", yumi_m, 9'h004);
        tick();
        chk("mesh_bp_last_gid", gid_m, 2);
        v_m = '0;
        tick();
        chk("mesh_bp_drain_v", vo_m, 0);

        // Crossbar fixed priority
        v_x = 9'h1FF;
        #1; chk("xbar_yumi0", yumi_x, 9'h001);
        tick(); chk("xbar_gid_a", gid_x, 0);
        chk("xbar_yumi_again", yumi_x, 9'h001);
        tick(); chk("xbar_gid_b", gid_x, 0);
        v_x = 9'h1FE;
        #1; chk("xbar_yumi1", yumi_x, 9'h002);
        tick(); chk("xbar_gid1", gid_x, 1);
        chk("xbar_data1", do_x, pkt(1));
        v_x = 9'h100;
        #1; chk("xbar_yumi8", yumi_x, 9'h100);
        tick(); chk("xbar_gid8", gid_x, 8);
        v_x = '0;
        tick(); chk("xbar_drain_v", vo_x, 0);

        // Full ruche: grant 7 to set ptr=8, then alternate 8/0 with wrap
        v_r = 9'h080;
        #1; chk("ruche_yumi7", yumi_r, 9'h080);
        tick(); chk("ruche_gid7", gid_r, 7);
        v_r = 9'h101;
        #1; chk("ruche_yumi_p8", yumi_r, 9'h100);
        tick(); chk("ruche_gid8a", gid_r, 8);
        chk("ruche_yumi_wrap", yumi_r, 9'h001);
        tick(); chk("ruche_gid0", gid_r, 0);
        chk("ruche_data0", do_r, pkt(0));
        chk("ruche_yumi_p1", yumi_r, 9'h100);
        tick(); chk("ruche_gid8b", gid_r, 8);
        v_r = '0;
        tick(); chk("ruche_drain_v", vo_r, 0);

        // Mid-cycle async reset while mesh holds a packet with ptr=3
        v_m = 9'h004;
        tick(); chk("mesh_prerst_gid", gid_m, 2);
        rdy_m = 1'b0; v_m = 9'h00A;
        #2; reset_n_i = 1'b0;
        #1;
        chk("mrst_v", vo_m, 0);
        chk("mrst_gid", gid_m, 0);
        chk("mrst_yumi", yumi_m, 0);
        #2; reset_n_i = 1'b1; rdy_m = 1'b1;
        #1; chk("mrst_after_yumi", yumi_m, 9'h002);
        tick();
        chk("mrst_after_gid", gid_m, 1);
        chk("mrst_after_v", vo_m, 1);
        v_m = '0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/bsg_manycore_net_port_arbiter.md
BSG_MANYCORE_NET_PORT_ARBITER -- requirements
Module: bsg_manycore_net_port_arbiter

Interface
REQ-001 SHALL have parameter network_cfg_p, default e_network_mesh, selecting the network topology (bsg_manycore_network_cfg_e).
REQ-002 SHALL have parameter width_p, default 32, giving the packet width in bits.
REQ-003 SHALL have parameter num_in_p, default 9, giving the physical input count; it SHALL be at least the active count of REQ-015.
REQ-004 SHALL have port clk_i, input, 1 bit: the single clock.
REQ-005 SHALL have port reset_n_i, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port v_i, input, num_in_p bits: per-input packet valid.
REQ-007 SHALL have port data_i, input, num_in_p*width_p bits: input packets, input i at bits [i*width_p +: width_p].
REQ-008 SHALL have port yumi_o, output, num_in_p bits: per-input dequeue, at most one bit set.
REQ-009 SHALL have port v_o, output, 1 bit: output packet valid.
REQ-010 SHALL have port data_o, output, width_p bits: output packet.
REQ-011 SHALL have port ready_i, input, 1 bit: downstream can accept.
REQ-012 SHALL have port grant_id_o, output, `BSG_SAFE_CLOG2(num_in_p) bits: index of the input that sourced data_o.

Function
REQ-013 SHALL hold one output register (valid, data, grant_id) that drives v_o, data_o and grant_id_o directly.
REQ-014 SHALL treat the register as "open" when v_o=0, or when v_o=1 and ready_i=1.
REQ-015 SHALL set the active input count from network_cfg_p:
- mesh and torus: 5
- half_ruche_x: 7
- full_ruche: 9
- crossbar: num_in_p
REQ-016 SHALL ignore v_i on inactive inputs and hold their yumi_o at 0.
REQ-017 SHALL, when the register is open and any active v_i=1, assert yumi_o for exactly one winner in the same cycle (combinational), and load data_i[winner] and winner into the register at the next clock edge.
REQ-018 SHALL give a latency of 1 cycle from yumi_o to v_o=1 with that packet; back-to-back grants SHALL sustain 1 packet/cycle while ready_i=1.
REQ-019 SHALL, while v_o=1 and ready_i=0, keep data_o and grant_id_o stable and keep all yumi_o at 0.
REQ-020 SHALL clear v_o at the edge where v_o=1, ready_i=1 and no active v_i is asserted.
REQ-021 SHALL, for crossbar, use fixed priority with the lowest index winning; the pointer is unused.
REQ-022 SHALL, for all other topologies, use round-robin from a priority pointer ptr:
- the winner is the first valid index at or after ptr, wrapping modulo the active count
- after a grant to i, ptr becomes (i+1) mod active count, i.e. wraps from active-1 to 0
- ptr SHALL be unchanged when there is no grant
REQ-023 SHALL let a valid input wait at most (active count - 1) grants before it is served.
REQ-024 SHALL let v_i change freely when not granted; the block SHALL not require v_i to be held.
REQ-025 SHALL treat network_cfg_p = e_network_max_val as illegal and flag it with an elaboration-time error.
REQ-026 SHALL fire a simulation assertion if more than one yumi_o bit is set in a cycle.

Reset
REQ-027 SHALL, while reset_n_i=0, force v_o=0, grant_id_o=0, ptr=0 and yumi_o=0 asynchronously; data_o is don't-care.
REQ-028 SHALL, when reset_n_i is asserted mid-transfer, drop the held packet with no yumi_o re-issue; the upstream already dequeued it.
REQ-029 SHALL allow the first grant in the first cycle after reset_n_i deasserts.

Verification
REQ-030 Mesh, ready_i=1, v_i=5'b11111 held for 6 cycles -> grant_id_o sequence 0,1,2,3,4,0, one packet per cycle.
REQ-031 Mesh, v_i[8:5]=1 and v_i[4:0]=0 -> yumi_o=0 and v_o stays 0.
REQ-032 Mesh, one packet held with ready_i=0 for 4 cycles while v_i=5'b00110 -> data_o stable, yumi_o=0; when ready_i rises, the next grant goes to input 1 or 2 per ptr in the same cycle.
REQ-033 Crossbar, v_i=9'h1FF, ready_i=1 -> input 0 granted every cycle; after v_i[0] drops, input 1 is granted.
REQ-034 Full ruche, only v_i[8] and v_i[0] set, ptr=8 -> grants 8, 0, 8, alternating; ptr wraps 8->0.
REQ-035 reset_n_i pulled low asynchronously mid-cycle with v_o=1 -> v_o=0 and yumi_o=0 immediately; after release, a grant occurs with ptr=0.
